// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/response bundle between the fetch unit and imem.
interface instr_fetch_unit_if;
    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic [31:0] ImemRdata;
    logic        ImemValid;

    modport master (
        output ImemReq,
        output ImemAddr,
        input  ImemRdata,
        input  ImemValid
    );

    modport slave (
        input  ImemReq,
        input  ImemAddr,
        output ImemRdata,
        output ImemValid
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Multi-cycle instruction fetch: IDLE -> FETCH (wait for imem) -> EXEC -> FETCH.
// Optional fetch-wait watchdog with sticky error state when FETCH_TIMEOUT_EN is defined.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      Branch,
    input  logic                      Jump,
    input  logic                      Zero,
    input  logic [31:0]               ImmExt,
    instr_fetch_unit_if.master        imem,
    output logic [31:0]               PC,
    output logic [31:0]               PCPlus4,
    output logic [31:0]               Instr,
    output logic [6:0]                Opcode,
    output logic [2:0]                funct3,
    output logic                      funct7b5,
    output logic [4:0]                Rs1,
    output logic [4:0]                Rs2,
    output logic [4:0]                Rd,
    output logic                      InstrValid,
    output logic                      FetchErr
);

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2
`ifdef FETCH_TIMEOUT_EN
        ,
        ST_ERR   = 2'd3
`endif
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_instr;
    logic            r_imem_req;
    logic            r_instr_valid;
    logic [XLEN-1:0] w_pc_next;
    logic [XLEN-1:0] w_pc_seq;
    logic [XLEN-1:0] w_pc_target;
    logic [XLEN-1:0] w_pc_sum;
    logic [XLEN-1:0] w_pc_exec_next;
    logic            w_pc_src;
    logic            w_instr_load;

`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             r_fetch_err;
    logic             w_cnt_expire;

    // Last allowed empty FETCH cycle: one more miss means the watchdog fires.
    assign w_cnt_expire = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic w_unused_timeout;
    assign w_unused_timeout = ^XLEN'(TIMEOUT_CYCLES);
`endif

    // Next-PC datapath, evaluated every cycle but only committed in EXEC.
    assign w_pc_src       = (Branch & Zero) | Jump;
    assign w_pc_seq       = r_pc + XLEN'(4);
    assign w_pc_target    = r_pc + ImmExt;
    assign w_pc_sum       = w_pc_src ? w_pc_target : w_pc_seq;
    assign w_pc_exec_next = w_pc_sum & ~XLEN'(3);

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and datapath control.
    always_comb begin
        w_next_state = r_state;
        w_pc_next    = r_pc;
        w_instr_load = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        w_cnt_next   = r_cnt;
`endif
        case (r_state)
            ST_IDLE: begin
                w_next_state = ST_FETCH;
`ifdef FETCH_TIMEOUT_EN
                w_cnt_next   = '0;
`endif
            end
            ST_FETCH: begin
                if (imem.ImemValid) begin
                    w_next_state = ST_EXEC;
                    w_instr_load = 1'b1;
                end
`ifdef FETCH_TIMEOUT_EN
                else if (w_cnt_expire) begin
                    w_next_state = ST_ERR;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
`endif
            end
            ST_EXEC: begin
                w_next_state = ST_FETCH;
                w_pc_next    = w_pc_exec_next;
`ifdef FETCH_TIMEOUT_EN
                w_cnt_next   = '0;
`endif
            end
`ifdef FETCH_TIMEOUT_EN
            ST_ERR: begin
                w_next_state = ST_ERR;
            end
`endif
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Datapath registers; handshake outputs are decoded from the next state so they
    // line up with the state they describe.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_pc          <= RESET_PC;
            r_instr       <= NOP_INSTR;
            r_imem_req    <= 1'b0;
            r_instr_valid <= 1'b0;
        end else begin
            r_pc          <= w_pc_next;
            r_imem_req    <= (w_next_state == ST_FETCH);
            r_instr_valid <= (w_next_state == ST_EXEC);
            if (w_instr_load) begin
                r_instr <= imem.ImemRdata;
            end
        end
    end

`ifdef FETCH_TIMEOUT_EN
    // Watchdog counter and sticky error flag.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cnt       <= '0;
            r_fetch_err <= 1'b0;
        end else begin
            r_cnt       <= w_cnt_next;
            r_fetch_err <= (w_next_state == ST_ERR);
        end
    end

    assign FetchErr = r_fetch_err;
`else
    assign FetchErr = 1'b0;
`endif

    assign imem.ImemReq  = r_imem_req;
    assign imem.ImemAddr = r_pc;
    assign PC            = r_pc;
    assign PCPlus4       = w_pc_seq;
    assign Instr         = r_instr;
    assign InstrValid    = r_instr_valid;

    // Instruction field decode.
    assign Opcode   = r_instr[6:0];
    assign Rd       = r_instr[11:7];
    assign funct3   = r_instr[14:12];
    assign Rs1      = r_instr[19:15];
    assign Rs2      = r_instr[24:20];
    assign funct7b5 = r_instr[30];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed testbench for instr_fetch_unit; covers the watchdog when FETCH_TIMEOUT_EN is defined.
module tb_instr_fetch_unit;

    logic        clk;
    logic        reset_n;
    logic        Branch;
    logic        Jump;
    logic        Zero;
    logic [31:0] ImmExt;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic [31:0] Instr;
    logic [6:0]  Opcode;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic [4:0]  Rs1;
    logic [4:0]  Rs2;
    logic [4:0]  Rd;
    logic        InstrValid;
    logic        FetchErr;

    int n_checks = 0;
    int n_errors = 0;

    instr_fetch_unit_if u_if ();

    instr_fetch_unit #(
        .RESET_PC       (32'h0000_0000),
        .TIMEOUT_CYCLES (255)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .Branch     (Branch),
        .Jump       (Jump),
        .Zero       (Zero),
        .ImmExt     (ImmExt),
        .imem       (u_if),
        .PC         (PC),
        .PCPlus4    (PCPlus4),
        .Instr      (Instr),
        .Opcode     (Opcode),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .Rs1        (Rs1),
        .Rs2        (Rs2),
        .Rd         (Rd),
        .InstrValid (InstrValid),
        .FetchErr   (FetchErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n        = 1'b0;
        Branch         = 1'b0;
        Jump           = 1'b0;
        Zero           = 1'b0;
        ImmExt         = 32'h0;
        u_if.ImemValid = 1'b0;
        u_if.ImemRdata = 32'h0;
        step(2);

        // Reset state
        chk("rst_pc",     PC,                 32'h0);
        chk("rst_addr",   u_if.ImemAddr,      32'h0);
        chk("rst_req",    32'(u_if.ImemReq),  32'h0);
        chk("rst_ivalid", 32'(InstrValid),    32'h0);
        chk("rst_instr",  Instr,              32'h0000_0013);
        chk("rst_opcode", 32'(Opcode),        32'h13);
        chk("rst_err",    32'(FetchErr),      32'h0);

        // First fetch with an immediately valid response
        reset_n        = 1'b1;
        u_if.ImemValid = 1'b1;
        u_if.ImemRdata = 32'h0050_0093;
        step(1);
        chk("f1_req",    32'(u_if.ImemReq), 32'h1);
        chk("f1_ivalid", 32'(InstrValid),   32'h0);
        chk("f1_addr",   u_if.ImemAddr,     32'h0);
        step(1);
        chk("e1_ivalid", 32'(InstrValid),   32'h1);
        chk("e1_req",    32'(u_if.ImemReq), 32'h0);
        chk("e1_instr",  Instr,             32'h0050_0093);
        chk("e1_opcode", 32'(Opcode),       32'h13);
        chk("e1_rd",     32'(Rd),           32'h1);
        chk("e1_rs1",    32'(Rs1),          32'h0);
        chk("e1_rs2",    32'(Rs2),          32'h5);
        chk("e1_f3",     32'(funct3),       32'h0);
        chk("e1_pc",     PC,                32'h0);
        chk("e1_pc4",    PCPlus4,           32'h4);
        step(1);
        chk("f2_pc",     PC,                32'h4);
        chk("f2_req",    32'(u_if.ImemReq), 32'h1);
        chk("f2_ivalid", 32'(InstrValid),   32'h0);

        // Back-to-back sequential instructions: 0x4 -> 0x10
        step(6);
        chk("seq_pc", PC, 32'h10);

        // Branch taken backwards
        Branch = 1'b1;
        Zero   = 1'b1;
        ImmExt = 32'hFFFF_FFF8;
        step(1);
        chk("br_t_ivalid", 32'(InstrValid), 32'h1);
        step(1);
        chk("br_t_pc", PC, 32'h08);

        // Branch not taken
        Branch = 1'b0;
        Zero   = 1'b0;
        step(4);
        chk("br_pre_pc", PC, 32'h10);
        Branch = 1'b1;
        step(2);
        chk("br_nt_pc", PC, 32'h14);
        Branch = 1'b0;

        // Jump with PCPlus4 link value
        step(6);
        chk("j_pre_pc", PC, 32'h20);
        Jump   = 1'b1;
        ImmExt = 32'h0000_0100;
        step(1);
        chk("j_exec_pc",  PC,      32'h20);
        chk("j_exec_pc4", PCPlus4, 32'h24);
        step(1);
        chk("j_pc", PC, 32'h120);

        // Wrap-around at the top of the address space
        ImmExt = 32'hFFFF_FEDC;
        step(2);
        chk("wrap_pre_pc",  PC,      32'hFFFF_FFFC);
        chk("wrap_pre_pc4", PCPlus4, 32'h0);
        Jump = 1'b0;
        step(2);
        chk("wrap_pc", PC, 32'h0);

        // Misaligned target has its low bits cleared
        Jump   = 1'b1;
        ImmExt = 32'h0000_0007;
        step(2);
        chk("align_pc", PC, 32'h4);

        // Zero without Branch does not redirect
        Jump   = 1'b0;
        Zero   = 1'b1;
        ImmExt = 32'h0000_0040;
        step(2);
        chk("zero_only_pc", PC, 32'h8);
        Zero = 1'b0;

        // Delayed memory response: three empty FETCH cycles
        u_if.ImemValid = 1'b0;
        u_if.ImemRdata = 32'h4020_8133;
        for (int i = 0; i < 3; i++) begin
            chk("dly_req",    32'(u_if.ImemReq), 32'h1);
            chk("dly_addr",   u_if.ImemAddr,     32'h8);
            chk("dly_ivalid", 32'(InstrValid),   32'h0);
            step(1);
        end
        u_if.ImemValid = 1'b1;
        chk("dly_req4",  32'(u_if.ImemReq), 32'h1);
        chk("dly_addr4", u_if.ImemAddr,     32'h8);
        step(1);
        chk("dly_ivalid", 32'(InstrValid),   32'h1);
        chk("dly_req_lo", 32'(u_if.ImemReq), 32'h0);
        chk("dly_instr",  Instr,             32'h4020_8133);
        chk("dly_opcode", 32'(Opcode),       32'h33);
        chk("dly_rd",     32'(Rd),           32'h2);
        chk("dly_rs1",    32'(Rs1),          32'h1);
        chk("dly_rs2",    32'(Rs2),          32'h2);
        chk("dly_f7b5",   32'(funct7b5),     32'h1);
        u_if.ImemValid = 1'b0;
        step(1);
        chk("dly_ivalid_off", 32'(InstrValid), 32'h0);
        chk("dly_pc",         PC,              32'hC);

        // Reset in the middle of a FETCH wait; a late response is ignored
        step(1);
        chk("mid_req", 32'(u_if.ImemReq), 32'h1);
        reset_n = 1'b0;
        step(1);
        chk("mid_rst_pc",     PC,                32'h0);
        chk("mid_rst_req",    32'(u_if.ImemReq), 32'h0);
        chk("mid_rst_ivalid", 32'(InstrValid),   32'h0);
        chk("mid_rst_instr",  Instr,             32'h0000_0013);
        reset_n        = 1'b1;
        u_if.ImemValid = 1'b1;
        u_if.ImemRdata = 32'hDEAD_BEEF;
        step(1);
        chk("late_req",   32'(u_if.ImemReq), 32'h1);
        chk("late_instr", Instr,             32'h0000_0013);
        chk("late_pc",    PC,                32'h0);
        u_if.ImemValid = 1'b0;
        step(1);
        chk("late_instr2",  Instr,           32'h0000_0013);
        chk("late_ivalid2", 32'(InstrValid), 32'h0);

`ifdef FETCH_TIMEOUT_EN
        // Watchdog fires after 255 empty FETCH cycles and stays set
        reset_n = 1'b0;
        step(1);
        reset_n = 1'b1;
        step(1);
        step(254);
        chk("to_req_255", 32'(u_if.ImemReq), 32'h1);
        chk("to_err_255", 32'(FetchErr),     32'h0);
        step(1);
        chk("to_err",     32'(FetchErr),     32'h1);
        chk("to_req",     32'(u_if.ImemReq), 32'h0);
        u_if.ImemValid = 1'b1;
        step(5);
        chk("to_err_hold", 32'(FetchErr),     32'h1);
        chk("to_pc_hold",  PC,                32'h0);
        chk("to_ivalid",   32'(InstrValid),   32'h0);
        chk("to_req_hold", 32'(u_if.ImemReq), 32'h0);
        u_if.ImemValid = 1'b0;
        reset_n        = 1'b0;
        step(1);
        chk("to_rst_err", 32'(FetchErr), 32'h0);

        // Response on the last allowed cycle wins over the watchdog
        reset_n = 1'b1;
        step(1);
        step(254);
        u_if.ImemValid = 1'b1;
        u_if.ImemRdata = 32'h0050_0093;
        step(1);
        chk("edge_ivalid", 32'(InstrValid), 32'h1);
        chk("edge_err",    32'(FetchErr),   32'h0);
        chk("edge_instr",  Instr,           32'h0050_0093);
        u_if.ImemValid = 1'b0;
        step(1);
        chk("edge_pc",  PC,             32'h4);
        chk("edge_err2", 32'(FetchErr), 32'h0);
`else
        // Without the watchdog a FETCH waits indefinitely
        step(300);
        chk("nto_req", 32'(u_if.ImemReq), 32'h1);
        chk("nto_err", 32'(FetchErr),     32'h0);
        chk("nto_pc",  PC,                32'h0);
        u_if.ImemValid = 1'b1;
        u_if.ImemRdata = 32'h0050_0093;
        step(1);
        chk("nto_ivalid", 32'(InstrValid), 32'h1);
        chk("nto_instr",  Instr,           32'h0050_0093);
        chk("nto_err2",   32'(FetchErr),   32'h0);
        u_if.ImemValid = 1'b0;
        step(1);
        chk("nto_pc2", PC, 32'h4);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL provide parameter TIMEOUT_CYCLES, default 255, fetch-wait limit; used only with FETCH_TIMEOUT_EN.
REQ-003 SHALL provide port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL provide port reset_n  input  1  synchronous, active-low reset.
REQ-005 SHALL provide port Branch  input  1  branch instruction flag from control_unit.
REQ-006 SHALL provide port Jump  input  1  jump instruction flag from control_unit.
REQ-007 SHALL provide port Zero  input  1  ALU zero flag.
REQ-008 SHALL provide port ImmExt  input  32  sign-extended branch/jump offset.
REQ-009 SHALL provide port ImemRdata  input  32  instruction word from instruction memory.
REQ-010 SHALL provide port ImemValid  input  1  ImemRdata valid this cycle.
REQ-011 SHALL provide port ImemReq  output  1  fetch request to instruction memory.
REQ-012 SHALL provide port ImemAddr  output  32  fetch address; equals PC.
REQ-013 SHALL provide port PC  output  32  address of the current instruction.
REQ-014 SHALL provide port PCPlus4  output  32  PC+4, link value for JAL.
REQ-015 SHALL provide port Instr  output  32  registered instruction word.
REQ-016 SHALL provide ports Opcode (7), funct3 (3), funct7b5 (1), Rs1 (5), Rs2 (5), Rd (5), all outputs, as fields of Instr.
REQ-017 SHALL provide port InstrValid  output  1  Instr and downstream control are valid; qualifies register/memory writes.
REQ-018 SHALL provide port FetchErr  output  1  sticky fetch timeout flag.

Function
REQ-019 SHALL implement states IDLE, FETCH, EXEC, plus ERR when FETCH_TIMEOUT_EN is defined.
REQ-020 IDLE SHALL transition unconditionally to FETCH on the next cycle; ImemReq=0, InstrValid=0.
REQ-021 FETCH SHALL assert ImemReq and hold ImemAddr=PC stable until ImemValid is sampled high.
REQ-022 On ImemValid=1 in FETCH, Instr SHALL load ImemRdata and the state SHALL move to EXEC.
REQ-023 ImemValid SHALL be ignored in IDLE, EXEC and ERR.
REQ-024 EXEC SHALL last exactly one cycle with InstrValid=1 and ImemReq=0, then return to FETCH.
REQ-025 At the end of EXEC, PC SHALL load PCNext = PCSrc ? PC+ImmExt : PC+4, where PCSrc = (Branch & Zero) | Jump.
REQ-026 PCNext arithmetic SHALL be modulo 2^32 (0xFFFFFFFC+4 = 0x00000000), with bits [1:0] forced to 0.
REQ-027 PC SHALL NOT change in any state other than EXEC (except on reset).
REQ-028 Field outputs SHALL be combinational from Instr: Opcode=[6:0], Rd=[11:7], funct3=[14:12], Rs1=[19:15], Rs2=[24:20], funct7b5=[30].
REQ-029 PCPlus4 and ImemAddr SHALL be combinational from PC.
REQ-030 Minimum throughput SHALL be one instruction per 2 cycles (FETCH with immediate ImemValid, then EXEC).

Reset
REQ-031 With reset_n=0 at a rising edge: state=IDLE, PC=RESET_PC, Instr=32'h0000_0013 (NOP), InstrValid=0, ImemReq=0, FetchErr=0, timeout counter=0.
REQ-032 Reset SHALL take priority over every transition, including mid-FETCH wait, EXEC and ERR; any outstanding response is discarded.

Configuration
REQ-033 Macro FETCH_TIMEOUT_EN defined: a counter SHALL clear on FETCH entry and increment each FETCH cycle with ImemValid=0; on reaching TIMEOUT_CYCLES the state SHALL go to ERR.
REQ-034 In ERR: FetchErr=1, ImemReq=0, InstrValid=0, PC held, until reset.
REQ-035 ImemValid=1 in the same cycle the counter reaches TIMEOUT_CYCLES SHALL win: the instruction is accepted, go to EXEC, no error.
REQ-036 FETCH_TIMEOUT_EN undefined: no counter and no ERR state; FetchErr tied to 0; FETCH waits indefinitely.

Verification
REQ-037 Reset release, ImemValid=1 on first FETCH with 32'h0050_0093 -> ImemReq high cycle 1, InstrValid high cycle 2, Opcode=0010011, Rd=1, PC becomes 0x4.
REQ-038 PC=0x10, Branch=1, ImmExt=0xFFFFFFF8: Zero=1 -> PC=0x08; Zero=0 -> PC=0x14; PC=0xFFFFFFFC without branch -> PC=0x0.
REQ-039 PC=0x20, Jump=1, ImmExt=0x100 -> PCPlus4=0x24 during EXEC, next PC=0x120.
REQ-040 ImemValid delayed 3 cycles -> ImemReq high 4 cycles, ImemAddr constant, InstrValid high exactly 1 cycle.
REQ-041 reset_n=0 during FETCH wait -> next cycle IDLE, PC=RESET_PC, ImemReq=0; a late ImemValid is ignored.
REQ-042 FETCH_TIMEOUT_EN on, ImemValid never -> FetchErr=1 after 255 FETCH cycles, held until reset; ImemValid on cycle 255 -> normal EXEC, FetchErr=0.
